// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle one.
module ex_muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] RS1_i,
  input  logic [31:0] RS2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] result_o
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_nx, prod;
  logic [31:0] opd, a_mag, b_mag, quo, rem, fin, div_res, byp_res;
  logic [32:0] mul_sum, div_r, div_diff;
  logic [2:0]  op_q;
  logic        neg_q, rneg_q, s1, s2, a_neg, b_neg, accept, div_byp, bypass;
  assign s1 = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
  assign s2 = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
  assign a_neg = s1 & RS1_i[31];
  assign b_neg = s2 & RS2_i[31];
  assign a_mag = a_neg ? -RS1_i : RS1_i;
  assign b_mag = b_neg ? -RS2_i : RS2_i;
  assign accept = state == IDLE && start_i && !flush_i;
  // divide by zero and signed overflow have fixed RISC-V results
  assign div_byp = RS2_i == 32'd0 || (!op_i[0] && RS1_i == 32'h8000_0000 && RS2_i == 32'hFFFF_FFFF);
  assign div_res = RS2_i == 32'd0 ? (op_i[1] ? RS1_i : 32'hFFFF_FFFF) : (op_i[1] ? 32'd0 : 32'h8000_0000);
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast;
  assign fast = {{32{a_neg}}, RS1_i} * {{32{b_neg}}, RS2_i};
  assign bypass = op_i[2] ? div_byp : 1'b1;
  assign byp_res = op_i[2] ? div_res : (op_i[1:0] == 2'b00 ? fast[31:0] : fast[63:32]);
`else
  assign bypass = op_i[2] & div_byp;
  assign byp_res = div_res;
`endif
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
  assign div_r = acc[63:31];
  assign div_diff = div_r - {1'b0, opd};
  assign acc_nx = state == MUL ? {mul_sum, acc[31:1]} :
                  div_diff[32] ? {div_r[31:0], acc[30:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
  assign prod = neg_q ? -acc_nx : acc_nx;
  assign quo = neg_q ? -acc_nx[31:0] : acc_nx[31:0];
  assign rem = rneg_q ? -acc_nx[63:32] : acc_nx[63:32];
  assign fin = state == MUL ? (op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32]) : (op_q[1] ? rem : quo);
  assign stall_o = !rst_i && (accept || state == MUL || state == DIV);
  assign valid_o = state == DONE;
  always_comb begin
    state_nx = flush_i ? IDLE :
               state == IDLE ? (start_i ? (bypass ? DONE : (op_i[2] ? DIV : MUL)) : IDLE) :
               state == DONE ? IDLE :
               cnt == 5'd31 ? DONE : state;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      acc <= '0;
      opd <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
      op_q <= op_i;
      neg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      acc <= {32'd0, a_mag};
      opd <= b_mag;
      if (bypass) result_o <= byp_res;
    end else if (state == MUL || state == DIV) begin
      cnt <= cnt + 5'd1;
      acc <= acc_nx;
      if (cnt == 5'd31) result_o <= fin;
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: random and directed checks of ex_muldiv against a cycle-budget arithmetic model.
module tb_ex_muldiv;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, flush_i = 1'b0;
  logic [2:0] op_i = 3'd0;
  logic [31:0] RS1_i = 32'd0, RS2_i = 32'd0;
  logic stall_o, valid_o;
  logic [31:0] result_o;
  int cmp_n = 0, err_n = 0;
  int m_left = 0;
  logic m_valid = 1'b0;
  logic [31:0] m_res = 32'd0, m_pend = 32'd0;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int LM = FAST ? 1 : 33;
  ex_muldiv dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .RS1_i(RS1_i),
                 .RS2_i(RS2_i), .flush_i(flush_i), .stall_o(stall_o), .valid_o(valid_o), .result_o(result_o));
  always #5 clk_i = ~clk_i;
  function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic bit is_byp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] ? (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) : FAST;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: an accepted iterative op finishes 32 edges later, a bypassed one on the next edge
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_left <= 0;
      m_valid <= 1'b0;
      m_res <= 32'd0;
    end else if (flush_i) begin
      m_left <= 0;
      m_valid <= 1'b0;
    end else if (m_valid) begin
      m_valid <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_res <= m_pend;
      end
    end else if (start_i) begin
      if (is_byp(op_i, RS1_i, RS2_i)) begin
        m_valid <= 1'b1;
        m_res <= ref_calc(op_i, RS1_i, RS2_i);
      end else begin
        m_left <= 32;
        m_pend <= ref_calc(op_i, RS1_i, RS2_i);
      end
    end
  end
  always @(negedge clk_i) begin
    check("valid", {31'd0, valid_o}, {31'd0, m_valid});
    check("stall", {31'd0, stall_o}, {31'd0, !rst_i && (m_left > 0 || (!m_valid && start_i && !flush_i))});
    check("result", result_o, m_res);
  end
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int k;
    check({name, " model"}, ref_calc(op, a, b), exp);
    @(posedge clk_i); #2;
    start_i = 1'b1; op_i = op; RS1_i = a; RS2_i = b;
    @(posedge clk_i); #2;
    start_i = 1'b0;
    k = 1;
    while (!valid_o && k < 40) begin
      @(posedge clk_i); #2;
      k++;
    end
    check({name, " result"}, result_o, exp);
    check({name, " latency"}, 32'(k), 32'(lat));
  endtask
  initial begin
    int v;
    #12;
    check("reset result", result_o, 32'd0);
    check("reset valid", {31'd0, valid_o}, 32'd0);
    check("reset stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #2 rst_i = 1'b0;
    do_op("mul 7x6", 3'd0, 32'd7, 32'd6, 32'd42, LM);
    do_op("mulh -1x-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LM);
    do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LM);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LM);
    do_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("divu 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    do_op("remu 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    do_op("div 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("rem 5/0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    do_op("divu 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    do_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    @(posedge clk_i); #2;
    start_i = 1'b1; op_i = 3'd5; RS1_i = 32'd100; RS2_i = 32'd7;
    @(posedge clk_i); #2;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2 flush_i = 1'b1;
    @(posedge clk_i); #2 flush_i = 1'b0;
    check("flush stall", {31'd0, stall_o}, 32'd0);
    check("flush valid", {31'd0, valid_o}, 32'd0);
    check("flush result", result_o, 32'h8000_0000);
    v = 0;
    repeat (40) begin
      @(posedge clk_i); #2;
      v += int'(valid_o);
    end
    check("flush no pulse", 32'(v), 32'd0);
    do_op("divu after flush", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    @(posedge clk_i); #2;
    start_i = 1'b1; op_i = 3'd0; RS1_i = 32'd7; RS2_i = 32'd6;
    @(posedge clk_i); #2;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("async rst result", result_o, 32'd0);
    check("async rst valid", {31'd0, valid_o}, 32'd0);
    check("async rst stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #2 rst_i = 1'b0;
    do_op("mul 3x3", 3'd0, 32'd3, 32'd3, 32'd9, LM);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_i); #2;
      start_i = $urandom_range(0, 2) == 0;
      op_i = 3'($urandom_range(0, 7));
      RS1_i = pick();
      RS2_i = pick();
      flush_i = $urandom_range(0, 60) == 0;
    end
    @(posedge clk_i); #2;
    start_i = 1'b0;
    flush_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the forwarded RS1/RS2 operands and the M-extension function code from ID/EX and holds the front of the pipeline stalled while it computes. It then presents a 32-bit result, with a one-cycle valid pulse, to the EX/MEM register.

## Interface
Parameters:
- none

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  M-type instruction present in ID/EX; sampled only in IDLE.
- op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- RS1_i  input  32  operand A (dividend / multiplicand), post-forwarding.
- RS2_i  input  32  operand B (divisor / multiplier), post-forwarding.
- flush_i  input  1  abort current operation (branch/exception flush).
- stall_o  output  1  freeze PC, IF/ID and ID/EX.
- valid_o  output  1  result_o holds the finished result this cycle.
- result_o  output  32  result; held until the next accepted start.

## Operation
- States: IDLE, MUL, DIV, DONE. A 5-bit iteration counter; a 64-bit accumulator/remainder register; a 32-bit operand register; latched op and sign-fix flags.
- IDLE + start_i at an edge:
  - Latch op_i and operands.
  - For signed operands (MULH rs1/rs2, MULHSU rs1 only, DIV/REM both), store magnitudes and record result sign.
  - Go to MUL for op[2]=0, or DIV for op[2]=1. Counter = 0.
- Special divides bypass iteration; they go IDLE -> DONE directly:
  - RS2_i = 0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result RS1_i.
  - DIV/REM with RS1_i = 0x80000000 and RS2_i = 0xFFFFFFFF: DIV result 0x80000000; REM result 0.
- MUL: radix-2 shift-add, one multiplier bit per cycle, unsigned 64-bit product.
- DIV: restoring, one quotient bit per cycle, unsigned.
- After counter = 31, go to DONE. On that transition:
  - Apply sign fix (two's-complement negate of the 64-bit product, quotient, or remainder).
  - Remainder takes the dividend's sign.
  - Select the low word (MUL), high word (MULH*), quotient, or remainder into result_o.
- DONE: valid_o = 1 for exactly one cycle, then IDLE. start_i is ignored in DONE, because the same ID/EX instruction is still present.
- flush_i at any edge: state -> IDLE, counter cleared, no valid_o pulse, result_o unchanged. flush_i has priority over start_i.
- stall_o = (IDLE & start_i & ~flush_i) | MUL | DIV; combinational; forced 0 while rst_i = 1.

## Timing
- Reset (asynchronous): state IDLE, counter 0, result_o 0, valid_o 0, stall_o 0. Reset asserted mid-operation discards the operation immediately.
- Iterative latency: start accepted at edge E0; valid_o = 1 in the cycle after edge E32. Total is 33 stall cycles, counting the start cycle.
- Bypass latency: valid_o = 1 in the cycle after E0; stall_o = 1 for the start cycle only.
- stall_o = 0 during the DONE cycle, so the pipeline captures result_o into EX/MEM on the edge that ends DONE.
- Back-to-back M instructions: the second start_i is accepted in the IDLE cycle after DONE.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MUL-class ops compute with a single-cycle 33x33 signed multiply at start.
  - Go IDLE -> DONE with bypass latency.
  - MUL state is unused.
- Undefined: 32-iteration shift-add multiplier as above. Divide behaviour is identical in both builds.

## Test plan
- MUL 7 x 6 (start 1 cycle) -> stall_o high 33 cycles, valid_o one cycle, result_o = 42. With MULDIV_FAST_MUL_EN: valid_o next cycle.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 / 2 -> 0xFFFFFFFF (-1); DIVU 100 / 7 -> 14, REMU -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF, REM 5 / 0 -> 5, DIV 0x80000000 / -1 -> 0x80000000. All with valid_o in the cycle after start.
- flush_i at iteration 10 of a DIV -> next cycle IDLE, stall_o 0, no valid_o, result_o retains previous value. A new start is then accepted normally.
- rst_i asserted asynchronously mid-MUL -> outputs 0 immediately. After release, a fresh MUL 3 x 3 yields 9.
